// File: rtl/isqrt_8bit_seq.sv
// isqrt_8bit_seq
// ---------------------------------------------------------------------------
// Sequential integer square root using the digit-by-digit restoring method.
// One root bit is retired per clock. For an operand x the block returns
// root = floor(sqrt(x)), rem = x - root^2 and perfect = (rem == 0).
//
// Ports
//   clk       in   1        rising-edge clock
//   rst       in   1        asynchronous, active-high reset
//   in_valid  in   1        operand offered on x
//   in_ready  out  1        block can accept an operand (IDLE)
//   x         in   WIDTH    unsigned operand, sampled on the accept edge only
//   out_valid out  1        root/rem/perfect hold a valid result
//   out_ready in   1        downstream consumes the result
//   root      out  WIDTH/2  floor(sqrt(x))
//   rem       out  WIDTH/2+1  x - root^2, range 0..2*root
//   perfect   out  1        rem == 0
//
// Timing: accept at edge k, out_valid high after edge k+WIDTH/2; results are
// held while out_valid && !out_ready; the block returns to IDLE on the edge
// that sees out_ready.
// ---------------------------------------------------------------------------
module isqrt_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem,
  output logic               perfect
);

  localparam int H  = WIDTH / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_x;    // operand, consumed two bits at a time from the top
  logic [H-1:0]    r_q;     // partial root
  logic [H-1:0]    r_r;     // partial remainder between iterations
  logic [CW-1:0]   r_cnt;   // iterations remaining after the current one

  // Datapath for one iteration, evaluated from the current registers.
  logic [H+1:0] w_r_sh;     // (r << 2) | next operand pair
  logic [H+1:0] w_trial;    // (q << 2) | 1
  logic [H+1:0] w_diff;
  logic         w_ge;
  logic [H:0]   w_r_nx;
  logic [H-1:0] w_q_nx;
  logic         w_unused_msb;

  assign w_r_sh  = {r_r, r_x[WIDTH-1 -: 2]};
  assign w_trial = {r_q, 2'b01};
  assign w_ge    = (w_r_sh >= w_trial);
  assign w_diff  = w_r_sh - w_trial;

  // The top bit of w_r_sh can only be set on the final iteration, and then
  // the trial value is always smaller, so the subtract path is taken and the
  // result (<= 2*root) fits in H+1 bits. Dropping the MSB is therefore safe.
  assign w_r_nx  = w_ge ? w_diff[H:0] : w_r_sh[H:0];
  assign w_q_nx  = (r_q << 1) | H'(w_ge);

  assign w_unused_msb = w_diff[H+1] ^ w_r_sh[H+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      root      <= '0;
      rem       <= '0;
      perfect   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x      <= x;
            r_q      <= '0;
            r_r      <= '0;
            r_cnt    <= CW'(H - 1);
            in_ready <= 1'b0;
            r_state  <= CALC;
          end
        end

        CALC: begin
          r_x <= r_x << 2;
          r_q <= w_q_nx;
          // Intermediate remainders stay below 2^H; only the final one
          // needs the extra bit, and it goes straight to rem.
          r_r <= w_r_nx[H-1:0];
          if (r_cnt == '0) begin
            root      <= w_q_nx;
            rem       <= w_r_nx;
            perfect   <= (w_r_nx == '0);
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/isqrt_8bit_seq.md
Name: isqrt_8bit_seq

Overview:
- Sequential integer square-root extractor. It is the inverse-direction companion to the 4-bit squarer.
- Takes an 8-bit unsigned operand x and returns root = floor(sqrt(x)), rem = x - root^2, and a perfect-square flag.
- Uses a digit-by-digit restoring algorithm that retires one root bit per clock.
- Sits behind a valid/ready handshake on both sides. It serves as the checker and decoder stage for squarer outputs in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. Root width is WIDTH/2; remainder width is WIDTH/2+1.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand offered on x
- in_ready  output  1  block can accept an operand
- x  input  WIDTH  unsigned operand
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  downstream consumes the result
- root  output  WIDTH/2  floor(sqrt(x))
- rem  output  WIDTH/2+1  x - root^2; range 0..2*root
- perfect  output  1  1 when rem == 0

Behaviour:
- Reset (async assert, any time): state=IDLE, in_ready=1, out_valid=0, root=0, rem=0, perfect=0, iteration counter=0, operand shift register=0. Any in-flight computation is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch x into the operand shift register, clear the root and partial-remainder accumulators, load counter=WIDTH/2-1, go to CALC.
  - x is sampled only at this edge.
- CALC:
  - in_ready=0, out_valid=0. One iteration per cycle.
  - Shift the top two operand bits into the partial remainder: r = (r<<2) | pair.
  - trial = (q<<2) | 1.
  - If r >= trial: r = r - trial, q = (q<<1) | 1. Otherwise q = q<<1.
  - Shift the operand left by 2.
  - At the iteration where counter==0: write q to root, r to rem, (r==0) to perfect; go to DONE. Otherwise decrement the counter.
- Arithmetic widths:
  - Partial remainder and trial are WIDTH/2+2 bits internally, so the compare never overflows.
  - Final rem fits in WIDTH/2+1 bits.
- DONE:
  - out_valid=1. root, rem and perfect are held stable while out_valid=1 && out_ready=0.
  - On an edge with out_ready=1, go to IDLE (out_valid=0, in_ready=1 next cycle).
- Outputs root, rem and perfect retain their last values in IDLE and CALC. They are meaningful only while out_valid=1.
- Latency:
  - Operand accepted at edge k; out_valid rises after edge k+WIDTH/2 (4 cycles for WIDTH=8).
  - Minimum initiation interval is WIDTH/2+2 cycles (accept, WIDTH/2 iterations, handshake out, return to IDLE).
- Boundary cases:
  - in_valid held high while busy is ignored; the operand is not consumed until in_ready=1.
  - out_ready high before out_valid has no effect.
  - x=0 yields root=0, rem=0, perfect=1.
  - x=2^WIDTH-1 yields the maximum rem, 2*root.
- Reset deasserted mid-operation: the block restarts in IDLE. No spurious out_valid is ever produced.

Test Plan:
- Basic results, one at a time, out_ready=1:
  - x=0 -> root=0, rem=0, perfect=1
  - x=1 -> root=1, rem=0, perfect=1
  - x=225 -> root=15, rem=0, perfect=1
  - x=200 -> root=14, rem=4, perfect=0
  - x=255 -> root=15, rem=30, perfect=0
  - In every case out_valid rises exactly 4 cycles after the accept edge.
- Backpressure: x=100 with out_ready=0 for 10 cycles -> out_valid stays 1; root=10, rem=0 stable; in_ready=0 throughout; accepts the next operand only after the cycle out_ready=1 is seen.
- Busy ignore: x=50 accepted, then in_valid=1 with x=81 held during CALC -> first result root=7, rem=1. The x=81 operand is accepted only when IDLE returns, giving root=9, rem=0.
- Reset mid-calc: assert rst 2 cycles after accepting x=169 -> out_valid=0 and in_ready=1 immediately (asynchronous). No result is emitted. A fresh x=16 then gives root=4, rem=0.
- Squarer round trip: for every a in 0..15, feed the squarer's Y as x -> root==a, rem==0, perfect==1.
- Exhaustive: all x in 0..255 with random out_ready stalls -> root^2 + rem == x, and rem <= 2*root.
